// File: rtl/status_pkg.sv
// ============================================================================
// Module : status_pkg
// Brief  : Flag bit indices and operation encodings for the status shift unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package status_pkg;

  // Flag vectors are packed {Z,C,N,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MU_LOAD_ALU = 2'd0,
    MU_LOAD_MA  = 2'd1,
    MU_SET      = 2'd2,
    MU_CLEAR    = 2'd3
  } mu_op_e;

  typedef enum logic [2:0] {
    MA_LOAD_ALU = 3'd0,
    MA_LOAD_MU  = 3'd1,
    MA_LOAD_D   = 3'd2,
    MA_SWAP     = 3'd3,
    MA_INV_C    = 3'd4,
    MA_CLEAR    = 3'd5,
    MA_HOLD6    = 3'd6,
    MA_HOLD7    = 3'd7
  } ma_op_e;

  typedef enum logic [1:0] {
    SH_FILL0   = 2'd0,
    SH_FILL1   = 2'd1,
    SH_ROTATE  = 2'd2,
    SH_CROSS   = 2'd3
  } shift_mode_e;

  typedef enum logic [2:0] {
    COND_Z  = 3'd0,
    COND_NZ = 3'd1,
    COND_C  = 3'd2,
    COND_NC = 3'd3,
    COND_N  = 3'd4,
    COND_V  = 3'd5,
    COND_LT = 3'd6,
    COND_LE = 3'd7
  } cond_sel_e;

endpackage

`default_nettype wire

// File: rtl/shift_linkage.sv
// ============================================================================
// Module : shift_linkage
// Brief  : Combinational routing of slice RAM/Q shift linkage signals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_linkage
  import status_pkg::*;
(
  input  logic       shift_en,
  input  logic       shift_dir,
  input  logic [1:0] shift_mode,
  input  logic       ram0_in,
  input  logic       ram3_in,
  input  logic       q0_in,
  input  logic       q3_in,
  input  logic       mu_n,
  output logic       ram0_out,
  output logic       ram3_out,
  output logic       q0_out,
  output logic       q3_out
);

  shift_mode_e mode_w;
  assign mode_w = shift_mode_e'(shift_mode);

  always_comb begin
    ram0_out = 1'b0;
    ram3_out = 1'b0;
    q0_out   = 1'b0;
    q3_out   = 1'b0;
    if (shift_en) begin
      if (!shift_dir) begin
        // Up shift: bits enter at the LSB end of RAM and Q
        unique case (mode_w)
          SH_FILL0:  begin ram0_out = 1'b0;    q0_out = 1'b0;    end
          SH_FILL1:  begin ram0_out = 1'b1;    q0_out = 1'b1;    end
          SH_ROTATE: begin ram0_out = ram3_in; q0_out = q3_in;   end
          SH_CROSS:  begin ram0_out = q3_in;   q0_out = ram3_in; end
          default:   ;
        endcase
      end else begin
        // Down shift: mode 1 replicates the micro sign for arithmetic shifts
        unique case (mode_w)
          SH_FILL0:  begin ram3_out = 1'b0;    q3_out = 1'b0;    end
          SH_FILL1:  begin ram3_out = mu_n;    q3_out = ram0_in; end
          SH_ROTATE: begin ram3_out = ram0_in; q3_out = q0_in;   end
          SH_CROSS:  begin ram3_out = q0_in;   q3_out = ram0_in; end
          default:   ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/status_shift_unit.sv
// ============================================================================
// Module : status_shift_unit
// Brief  : Micro/machine status registers, carry-in select, condition test
//          and shift linkage for an am2901-style slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_shift_unit
  import status_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c4,
  input  logic       ovr,
  input  logic       f3,
  input  logic       f30,
  input  logic       ram0_in,
  input  logic       ram3_in,
  input  logic       q0_in,
  input  logic       q3_in,
  input  logic [3:0] d_in,
  input  logic       ce_mu,
  input  logic       ce_ma,
  input  logic [1:0] mu_op,
  input  logic [2:0] ma_op,
  input  logic [1:0] cin_sel,
  input  logic       shift_en,
  input  logic       shift_dir,
  input  logic [1:0] shift_mode,
  input  logic [3:0] cond_sel,
  output logic [3:0] mu_flags,
  output logic [3:0] ma_flags,
  output logic       ram0_out,
  output logic       ram3_out,
  output logic       q0_out,
  output logic       q3_out,
  output logic       c0_out,
  output logic       ct
);

  logic [3:0] mu_flags_q, mu_flags_d;
  logic [3:0] ma_flags_q, ma_flags_d;
  logic [3:0] alu_flags_w;
  logic [3:0] sel_flags_w;
  logic       swap_w;
  mu_op_e     mu_op_w;
  ma_op_e     ma_op_w;
  cond_sel_e  cond_w;

  assign mu_op_w     = mu_op_e'(mu_op);
  assign ma_op_w     = ma_op_e'(ma_op);
  assign cond_w      = cond_sel_e'(cond_sel[2:0]);
  assign alu_flags_w = {f30, c4, f3, ovr};
  assign swap_w      = ce_ma && (ma_op_w == MA_SWAP);

  always_comb begin
    mu_flags_d = mu_flags_q;
    if (ce_mu) begin
      unique case (mu_op_w)
        MU_LOAD_ALU: mu_flags_d = alu_flags_w;
        MU_LOAD_MA:  mu_flags_d = ma_flags_q;
        MU_SET:      mu_flags_d = 4'b1111;
        MU_CLEAR:    mu_flags_d = 4'b0000;
        default:     mu_flags_d = mu_flags_q;
      endcase
    end
    // A machine-register swap owns the micro register on that edge
    if (swap_w) mu_flags_d = ma_flags_q;
  end

  always_comb begin
    ma_flags_d = ma_flags_q;
    if (ce_ma) begin
      unique case (ma_op_w)
        MA_LOAD_ALU: ma_flags_d = alu_flags_w;
        MA_LOAD_MU:  ma_flags_d = mu_flags_q;
        MA_LOAD_D:   ma_flags_d = d_in;
        MA_SWAP:     ma_flags_d = mu_flags_q;
        MA_INV_C:    ma_flags_d = ma_flags_q ^ (4'b0001 << FLAG_C);
        MA_CLEAR:    ma_flags_d = 4'b0000;
        default:     ma_flags_d = ma_flags_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu_flags_q <= 4'b0000;
      ma_flags_q <= 4'b0000;
    end else begin
      mu_flags_q <= mu_flags_d;
      ma_flags_q <= ma_flags_d;
    end
  end

  assign mu_flags = mu_flags_q;
  assign ma_flags = ma_flags_q;

  always_comb begin
    c0_out = 1'b0;
    unique case (cin_sel)
      2'd0:    c0_out = 1'b0;
      2'd1:    c0_out = 1'b1;
      2'd2:    c0_out = mu_flags_q[FLAG_C];
      2'd3:    c0_out = ma_flags_q[FLAG_C];
      default: c0_out = 1'b0;
    endcase
  end

  assign sel_flags_w = cond_sel[3] ? ma_flags_q : mu_flags_q;

  always_comb begin
    ct = 1'b0;
    unique case (cond_w)
      COND_Z:  ct = sel_flags_w[FLAG_Z];
      COND_NZ: ct = ~sel_flags_w[FLAG_Z];
      COND_C:  ct = sel_flags_w[FLAG_C];
      COND_NC: ct = ~sel_flags_w[FLAG_C];
      COND_N:  ct = sel_flags_w[FLAG_N];
      COND_V:  ct = sel_flags_w[FLAG_V];
      COND_LT: ct = sel_flags_w[FLAG_N] ^ sel_flags_w[FLAG_V];
      COND_LE: ct = sel_flags_w[FLAG_Z] | (sel_flags_w[FLAG_N] ^ sel_flags_w[FLAG_V]);
      default: ct = 1'b0;
    endcase
  end

  shift_linkage u_shift_linkage (
    .shift_en   (shift_en),
    .shift_dir  (shift_dir),
    .shift_mode (shift_mode),
    .ram0_in    (ram0_in),
    .ram3_in    (ram3_in),
    .q0_in      (q0_in),
    .q3_in      (q3_in),
    .mu_n       (mu_flags_q[FLAG_N]),
    .ram0_out   (ram0_out),
    .ram3_out   (ram3_out),
    .q0_out     (q0_out),
    .q3_out     (q3_out)
  );

endmodule

`default_nettype wire
